// File: rtl/acsp_pkg.sv
// Shared types and helpers for the analyzer capture path.
package acsp_pkg;
  localparam int SAMPLE_WIDTH_DEF = 8;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CAPTURE,
    ST_POST,
    ST_RD_ADDR,
    ST_RD_DATA,
    ST_SEND,
    ST_WAIT_TX
  } cap_state_t;

  function automatic int nbytes(input int width);
    return (width + 7) / 8;
  endfunction
endpackage

// File: rtl/capture_ram.sv
// Simple dual-port sample store: one write port, one registered read port, no reset.
module capture_ram #(
  parameter int SAMPLE_WIDTH = 8,
  parameter int DEPTH        = 1024,
  localparam int AW          = $clog2(DEPTH)
) (
  input  logic                    clock,
  input  logic                    i_we,
  input  logic [AW-1:0]           i_waddr,
  input  logic [SAMPLE_WIDTH-1:0] i_wdata,
  input  logic [AW-1:0]           i_raddr,
  output logic [SAMPLE_WIDTH-1:0] o_rdata
);
  logic [SAMPLE_WIDTH-1:0] r_mem [DEPTH];
  logic [SAMPLE_WIDTH-1:0] r_rdata;

  always_ff @(posedge clock) begin
    if (i_we) r_mem[i_waddr] <= i_wdata;
    r_rdata <= r_mem[i_raddr];
  end

  assign o_rdata = r_rdata;
endmodule

// File: rtl/capture_buffer.sv
// Circular capture memory with pre/post-trigger window, streamed oldest-first to the UART
// one byte per strobe, LSB byte first.
module capture_buffer
  import acsp_pkg::*;
#(
  parameter int SAMPLE_WIDTH = SAMPLE_WIDTH_DEF,
  parameter int DEPTH        = 1024,
  localparam int AW          = $clog2(DEPTH),
  localparam int CW          = AW + 1
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic                    arm,
  input  logic                    run,
  input  logic [SAMPLE_WIDTH-1:0] sample_in,
  input  logic                    sample_valid,
  input  logic [CW-1:0]           read_count,
  input  logic [CW-1:0]           delay_count,
  input  logic                    tx_busy,
  output logic [7:0]              tran_data,
  output logic                    tran_uart,
  output logic                    busy,
  output logic                    capture_done
);
  localparam int NB = nbytes(SAMPLE_WIDTH);
  localparam int SW = NB * 8;
  localparam int IW = (NB > 1) ? $clog2(NB) : 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

  function automatic logic [CW-1:0] sat_depth(input logic [CW-1:0] v);
    return (v > DEPTH_C) ? DEPTH_C : v;
  endfunction

  cap_state_t r_state, w_state_nxt;
  logic [AW-1:0] r_wr_ptr, r_rd_ptr, w_rd_ptr_nxt;
  logic [CW-1:0] r_stored, r_rd_n, r_dly, r_left, w_n;
  logic [IW-1:0] r_idx;
  logic [SW-1:0] r_shift;
  logic          r_first;
  logic [SAMPLE_WIDTH-1:0] w_rdata;
  logic          w_we, w_byte_done, w_last_byte;

  assign w_n         = (r_rd_n < r_stored) ? r_rd_n : r_stored;
  assign w_we        = !arm && sample_valid && (r_state == ST_CAPTURE || r_state == ST_POST);
  assign w_byte_done = (r_state == ST_WAIT_TX) && !r_first && !tx_busy;
  assign w_last_byte = (r_idx == IW'(NB - 1));
  assign busy        = (r_state != ST_IDLE);
  assign tran_data   = r_shift[7:0];

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) r_state <= ST_IDLE;
    else        r_state <= w_state_nxt;
  end

  // The RAM is addressed with the next read pointer so data is ready in RD_DATA.
  always_comb begin
    w_state_nxt  = r_state;
    w_rd_ptr_nxt = r_rd_ptr;
    tran_uart    = 1'b0;
    capture_done = 1'b0;
    case (r_state)
      ST_IDLE: ;
      ST_CAPTURE:
        if (run) w_state_nxt = (sample_valid && r_dly == '0) ? ST_RD_ADDR : ST_POST;
      ST_POST:
        if (sample_valid && r_dly <= CW'(1)) w_state_nxt = ST_RD_ADDR;
      ST_RD_ADDR:
        if (w_n == '0) begin
          capture_done = 1'b1;
          w_state_nxt  = ST_IDLE;
        end else begin
          w_rd_ptr_nxt = r_wr_ptr - w_n[AW-1:0];
          w_state_nxt  = ST_RD_DATA;
        end
      ST_RD_DATA: w_state_nxt = ST_SEND;
      ST_SEND:
        if (!tx_busy) begin
          tran_uart   = 1'b1;
          w_state_nxt = ST_WAIT_TX;
        end
      ST_WAIT_TX:
        if (w_byte_done) begin
          if (!w_last_byte) begin
            w_state_nxt = ST_SEND;
          end else if (r_left > CW'(1)) begin
            w_rd_ptr_nxt = r_rd_ptr + 1'b1;
            w_state_nxt  = ST_RD_DATA;
          end else begin
            capture_done = 1'b1;
            w_state_nxt  = ST_IDLE;
          end
        end
      default: w_state_nxt = ST_IDLE;
    endcase
    if (arm) begin
      w_state_nxt  = ST_CAPTURE;
      tran_uart    = 1'b0;
      capture_done = 1'b0;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_stored <= '0;
      r_rd_n   <= '0;
      r_dly    <= '0;
      r_left   <= '0;
      r_idx    <= '0;
      r_shift  <= '0;
      r_first  <= 1'b0;
    end else begin
      r_rd_ptr <= w_rd_ptr_nxt;
      // The UART raises busy a cycle late, so the first WAIT_TX cycle is skipped.
      r_first  <= tran_uart;
      if (arm) begin
        r_rd_n   <= sat_depth(read_count);
        r_dly    <= sat_depth(delay_count);
        r_wr_ptr <= '0;
        r_stored <= '0;
      end else begin
        if (w_we) begin
          r_wr_ptr <= r_wr_ptr + 1'b1;
          if (r_stored != DEPTH_C) r_stored <= r_stored + 1'b1;
        end
        if (r_state == ST_POST && sample_valid && r_dly != '0) r_dly <= r_dly - 1'b1;
        if (r_state == ST_RD_ADDR) r_left <= w_n;
        if (r_state == ST_RD_DATA) begin
          r_shift <= SW'(w_rdata);
          r_idx   <= '0;
        end
        if (w_byte_done) begin
          if (!w_last_byte) begin
            r_idx   <= r_idx + 1'b1;
            r_shift <= r_shift >> 8;
          end else begin
            r_left  <= r_left - 1'b1;
          end
        end
      end
    end
  end

  capture_ram #(
    .SAMPLE_WIDTH(SAMPLE_WIDTH),
    .DEPTH       (DEPTH)
  ) u_ram (
    .clock  (clock),
    .i_we   (w_we),
    .i_waddr(r_wr_ptr),
    .i_wdata(sample_in),
    .i_raddr(w_rd_ptr_nxt),
    .o_rdata(w_rdata)
  );
endmodule

// File: tb/tb_capture_buffer.sv
// Directed bench for capture_buffer: an 8-bit and a 12-bit instance (DEPTH=16) with a simple UART busy model.
module tb_capture_buffer;
  logic       clk = 1'b0;
  logic       rst_n, arm, run, valid, tx_busy;
  logic [7:0] s8;
  logic [11:0] s12;
  logic [4:0] rc, dc;
  logic [7:0] tran_data8, tran_data12;
  logic       tran_uart8, tran_uart12, busy8, busy12, done8, done12;

  int n_chk = 0;
  int n_err = 0;
  logic [7:0] q8[$];
  logic [7:0] q12[$];
  int nd8 = 0, nd12 = 0, viol = 0, bcnt = 0;
  int busy_mode = 0;
  logic busy_force = 1'b0;

  always #5 clk = ~clk;

  capture_buffer #(.SAMPLE_WIDTH(8), .DEPTH(16)) u_dut8 (
    .clock(clk), .reset(rst_n), .arm(arm), .run(run), .sample_in(s8),
    .sample_valid(valid), .read_count(rc), .delay_count(dc), .tx_busy(tx_busy),
    .tran_data(tran_data8), .tran_uart(tran_uart8), .busy(busy8), .capture_done(done8));

  capture_buffer #(.SAMPLE_WIDTH(12), .DEPTH(16)) u_dut12 (
    .clock(clk), .reset(rst_n), .arm(arm), .run(run), .sample_in(s12),
    .sample_valid(valid), .read_count(rc), .delay_count(dc), .tx_busy(tx_busy),
    .tran_data(tran_data12), .tran_uart(tran_uart12), .busy(busy12), .capture_done(done12));

  // Strobe/done monitor and UART busy model (busy held 5 cycles after a strobe).
  always @(negedge clk) begin
    if (tran_uart8) begin
      q8.push_back(tran_data8);
      if (tx_busy) viol++;
    end
    if (tran_uart12) begin
      q12.push_back(tran_data12);
      if (tx_busy) viol++;
    end
    if (done8) nd8++;
    if (done12) nd12++;
    if ((busy_mode == 1 && tran_uart8) || (busy_mode == 2 && tran_uart12)) bcnt = 5;
    else if (bcnt > 0) bcnt--;
    tx_busy = busy_force || (bcnt > 0);
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic sample_pt();
    @(negedge clk);
    #1;
  endtask

  task automatic arm_pulse(input int rcv, input int dcv);
    step();
    arm = 1'b1; rc = 5'(rcv); dc = 5'(dcv); valid = 1'b0; run = 1'b0;
    step();
    arm = 1'b0;
  endtask

  task automatic feed(input int first, input int last, input int trig);
    for (int v = first; v <= last; v++) begin
      step();
      s8 = 8'(v); s12 = 12'(v); valid = 1'b1; run = (v == trig);
    end
    step();
    valid = 1'b0; run = 1'b0;
  endtask

  task automatic wait_done8(input string tag, input int target);
    int cyc = 0;
    while (nd8 < target && cyc < 1000) begin
      sample_pt();
      cyc++;
    end
    chk(tag, nd8, target);
  endtask

  task automatic chk_q8(input string tag, input int base, input int idx, input int exp);
    logic [31:0] got;
    got = (base + idx < q8.size()) ? 32'(q8[base + idx]) : 32'hDEAD;
    chk($sformatf("%s[%0d]", tag, idx), got, exp);
  endtask

  initial begin
    int b8, bd8, b12, bd12;
    logic [7:0] exp12 [4];
    exp12[0] = 8'hBC; exp12[1] = 8'h0A; exp12[2] = 8'h23; exp12[3] = 8'h01;
    rst_n = 1'b0; arm = 1'b0; run = 1'b0; valid = 1'b0;
    s8 = '0; s12 = '0; rc = '0; dc = '0;
    repeat (3) step();
    sample_pt();
    chk("rst busy", busy8, 0);
    chk("rst uart", tran_uart8, 0);
    chk("rst done", done8, 0);
    chk("rst data", tran_data8, 0);
    chk("rst busy12", busy12, 0);
    step();
    rst_n = 1'b1;

    // Basic window: rc=8, dc=3, trigger at 0x0A.
    b8 = q8.size(); bd8 = nd8;
    arm_pulse(8, 3);
    sample_pt();
    chk("t1 busy after arm", busy8, 1);
    feed(0, 31, 10);
    wait_done8("t1 done", bd8 + 1);
    chk("t1 nbytes", q8.size() - b8, 8);
    for (int i = 0; i < 8; i++) chk_q8("t1 byte", b8, i, 6 + i);
    sample_pt();
    chk("t1 idle", busy8, 0);

    // Ring wrap: rc=16, dc=4, trigger at sample 40.
    b8 = q8.size(); bd8 = nd8;
    arm_pulse(16, 4);
    feed(0, 50, 40);
    wait_done8("t2 done", bd8 + 1);
    chk("t2 nbytes", q8.size() - b8, 16);
    for (int i = 0; i < 16; i++) chk_q8("t2 byte", b8, i, 29 + i);

    // Short fill: only 3 samples stored.
    b8 = q8.size(); bd8 = nd8;
    arm_pulse(10, 0);
    feed(0, 9, 2);
    wait_done8("t3 done", bd8 + 1);
    chk("t3 nbytes", q8.size() - b8, 3);
    for (int i = 0; i < 3; i++) chk_q8("t3 byte", b8, i, i);

    // 12-bit samples, two bytes each, with a slow UART.
    b12 = q12.size(); bd12 = nd12; bd8 = nd8;
    busy_mode = 2;
    arm_pulse(2, 1);
    step(); s12 = 12'hABC; s8 = 8'hBC; valid = 1'b1; run = 1'b1;
    step(); s12 = 12'h123; s8 = 8'h23; run = 1'b0;
    step(); valid = 1'b0;
    for (int c = 0; c < 400 && nd12 < bd12 + 1; c++) sample_pt();
    chk("t4 done", nd12, bd12 + 1);
    chk("t4 nbytes", q12.size() - b12, 4);
    for (int i = 0; i < 4; i++)
      chk($sformatf("t4 byte[%0d]", i), (b12 + i < q12.size()) ? 32'(q12[b12 + i]) : 32'hDEAD, 32'(exp12[i]));
    chk("t4 strobe while busy", viol, 0);
    wait_done8("t4 dut8 done", bd8 + 1);
    busy_mode = 0;
    repeat (8) step();

    // rc=0: done one cycle after the trigger, no bytes.
    b8 = q8.size(); bd8 = nd8;
    arm_pulse(0, 0);
    step(); s8 = 8'h77; valid = 1'b1; run = 1'b1;
    step(); valid = 1'b0; run = 1'b0;
    sample_pt();
    chk("t5 done pulse", done8, 1);
    sample_pt();
    chk("t5 done low", done8, 0);
    repeat (10) step();
    chk("t5 no bytes", q8.size() - b8, 0);

    // arm during readout aborts it.
    b8 = q8.size(); bd8 = nd8;
    busy_mode = 1;
    arm_pulse(8, 0);
    feed(0, 7, 7);
    for (int c = 0; c < 300 && q8.size() < b8 + 2; c++) sample_pt();
    arm_pulse(8, 0);
    repeat (40) step();
    chk("t5 abort nbytes", q8.size() - b8, 2);
    chk_q8("t5 abort byte", b8, 0, 0);
    chk_q8("t5 abort byte", b8, 1, 1);
    chk("t5 abort no done", nd8, bd8);
    sample_pt();
    chk("t5 abort busy", busy8, 1);
    busy_mode = 0;
    repeat (8) step();

    // Reset during POST.
    b8 = q8.size();
    arm_pulse(4, 5);
    feed(0, 2, 0);
    rst_n = 1'b0;
    sample_pt();
    chk("t6 post busy", busy8, 0);
    chk("t6 post uart", tran_uart8, 0);
    chk("t6 post done", done8, 0);
    chk("t6 post data", tran_data8, 0);
    step();
    rst_n = 1'b1;
    feed(0, 9, 3);
    repeat (20) step();
    chk("t6 post no bytes", q8.size() - b8, 0);
    sample_pt();
    chk("t6 post idle", busy8, 0);

    // Reset while stalled in SEND.
    b8 = q8.size();
    busy_force = 1'b1;
    arm_pulse(4, 0);
    step(); s8 = 8'h55; valid = 1'b1; run = 1'b0;
    step(); s8 = 8'h5A; run = 1'b1;
    step(); valid = 1'b0; run = 1'b0;
    repeat (6) step();
    sample_pt();
    chk("t6 send data", tran_data8, 8'h55);
    chk("t6 send stalled", tran_uart8, 0);
    chk("t6 send busy", busy8, 1);
    step();
    rst_n = 1'b0;
    sample_pt();
    chk("t6 send rst data", tran_data8, 0);
    chk("t6 send rst busy", busy8, 0);
    chk("t6 send rst uart", tran_uart8, 0);
    chk("t6 send rst done", done8, 0);
    step();
    rst_n = 1'b1;
    busy_force = 1'b0;
    repeat (30) step();
    chk("t6 send no bytes", q8.size() - b8, 0);
    sample_pt();
    chk("t6 send idle", busy8, 0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
